// File: rtl/sum_ser_pkg.sv
// sum_ser_pkg: shared types and frame-length helpers for the sum serializer.
// Optional parity bit is selected with the SUM_SER_PARITY_EN macro.
package sum_ser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } sum_ser_state_t;

  // Serial bits per frame (start + data + stop) without parity.
  function automatic int frame_bits_nopar(input int data_w);
    return data_w + 2;
  endfunction

  // Serial bits per frame (start + data + parity + stop) with parity.
  function automatic int frame_bits_par(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/sum_ser_fifo.sv
// sum_ser_fifo: small synchronous FIFO; full/empty are derived from count.
// Pointers wrap modulo DEPTH (DEPTH must be a power of two).
module sum_ser_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sum_serializer.sv
// sum_serializer: buffers sum words in a FIFO and sends each one as an
// idle-high serial frame (start 0, data LSB first, optional parity, stop 1).
// Define SUM_SER_PARITY_EN to insert an even-parity bit before stop.
module sum_serializer
  import sum_ser_pkg::*;
#(
  parameter int DATA_W       = 5,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tx_out,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  sum_ser_state_t    state;
  logic [TW-1:0]     timer;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              bit_end;
  logic              has_word;
`ifdef SUM_SER_PARITY_EN
  logic              par_bit;
`endif

  assign in_ready = fifo_count < CW'(DEPTH);
  assign push     = in_valid & in_ready;
  assign bit_end  = (timer == '0);
  assign has_word = (fifo_count != '0);

  sum_ser_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (head),
    .count   (fifo_count)
  );

  // Pop the head when a frame starts: from IDLE, or chained off a finished stop bit.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE: pop = has_word;
      ST_STOP: pop = bit_end & has_word;
      default: pop = 1'b0;
    endcase
  end

  // Sticky overflow flag for words offered while the FIFO is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid && !in_ready) begin
      ovf <= 1'b1;
    end
  end

  // Frame FSM with bit timer, shift register and registered line/busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
`ifdef SUM_SER_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (has_word) begin
            state   <= ST_START;
            shreg   <= head;
            timer   <= RELOAD;
            tx_out  <= 1'b0;
            tx_busy <= 1'b1;
`ifdef SUM_SER_PARITY_EN
            par_bit <= ^head;
`endif
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            tx_out  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            timer   <= RELOAD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            timer <= RELOAD;
            if (bit_idx == LAST_IDX) begin
`ifdef SUM_SER_PARITY_EN
              state  <= ST_PARITY;
              tx_out <= par_bit;
`else
              state  <= ST_STOP;
              tx_out <= 1'b1;
`endif
            end else begin
              tx_out  <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
`ifdef SUM_SER_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state  <= ST_STOP;
            tx_out <= 1'b1;
            timer  <= RELOAD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            if (has_word) begin
              state   <= ST_START;
              shreg   <= head;
              timer   <= RELOAD;
              tx_out  <= 1'b0;
`ifdef SUM_SER_PARITY_EN
              par_bit <= ^head;
`endif
            end else begin
              state   <= ST_IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
